// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch / control stage feeding the execute stage.
//   Fetches one 32-bit word per instruction over a read-only ready/valid port,
//   holds it for execute until i_finished, then advances or redirects the PC.
//   Halts (until reset) on an illegal instruction or a misaligned redirect.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   o_addr, i_data, i_rd_valid,
//   o_rd_ready                      instruction memory read port
//   o_inst, o_pc, o_inst_valid      instruction presented to execute
//   i_finished, i_pc_change,
//   i_new_pc, i_invalid_inst        execute feedback
//   o_halted, o_fault_misalign,
//   o_fault_pc                      halt status / fault info
//   o_retired                       completed-instruction counter (wraps)
module fetch_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [31:0]           o_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic [31:0]           o_inst,
  output logic [31:0]           o_pc,
  output logic                  o_inst_valid,
  input  logic                  i_finished,
  input  logic                  i_pc_change,
  input  logic [31:0]           i_new_pc,
  input  logic                  i_invalid_inst,
  output logic                  o_halted,
  output logic                  o_fault_misalign,
  output logic [31:0]           o_fault_pc,
  output logic [31:0]           o_retired
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        fault_mis_q, fault_mis_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    retired_d   = retired_q;
    fault_pc_d  = fault_pc_q;
    fault_mis_d = fault_mis_q;
    case (state_q)
      S_FETCH: begin
        // o_rd_ready is always high here, so valid alone is a transfer
        if (i_rd_valid) begin
          inst_d  = i_data[31:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_invalid_inst) begin
          state_d     = S_HALT;
          fault_pc_d  = pc_q;
          fault_mis_d = 1'b0;
        end else if (i_finished) begin
          if (i_pc_change && (i_new_pc[1:0] != 2'b00)) begin
            state_d     = S_HALT;
            fault_pc_d  = pc_q;
            fault_mis_d = 1'b1;
          end else begin
            pc_d      = i_pc_change ? i_new_pc : pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      retired_q   <= 32'd0;
      fault_pc_q  <= 32'd0;
      fault_mis_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      retired_q   <= retired_d;
      fault_pc_q  <= fault_pc_d;
      fault_mis_q <= fault_mis_d;
    end
  end

  // Handshake/status outputs are masked by reset so nothing is accepted or
  // advertised while reset is asserted, whatever the current state.
  assign o_rd_ready       = !i_rst && (state_q == S_FETCH);
  assign o_inst_valid     = !i_rst && (state_q == S_EXEC);
  assign o_halted         = !i_rst && (state_q == S_HALT);
  assign o_addr           = (state_q == S_FETCH) ? pc_q : 32'd0;
  assign o_inst           = (state_q == S_EXEC) ? inst_q : NOP_INST;
  assign o_pc             = pc_q;
  assign o_retired        = retired_q;
  assign o_fault_pc       = fault_pc_q;
  assign o_fault_misalign = fault_mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] o_addr;
  logic [31:0] i_data = 32'd0;
  logic        i_rd_valid = 1'b0;
  logic        o_rd_ready;
  logic [31:0] o_inst, o_pc;
  logic        o_inst_valid;
  logic        i_finished = 1'b0;
  logic        i_pc_change = 1'b0;
  logic [31:0] i_new_pc = 32'd0;
  logic        i_invalid_inst = 1'b0;
  logic        o_halted, o_fault_misalign;
  logic [31:0] o_fault_pc, o_retired;

  fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_addr(o_addr), .i_data(i_data),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .o_inst(o_inst),
    .o_pc(o_pc), .o_inst_valid(o_inst_valid), .i_finished(i_finished),
    .i_pc_change(i_pc_change), .i_new_pc(i_new_pc),
    .i_invalid_inst(i_invalid_inst), .o_halted(o_halted),
    .o_fault_misalign(o_fault_misalign), .o_fault_pc(o_fault_pc),
    .o_retired(o_retired)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [31:0] inst; logic [31:0] pc; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] exp_pc, exp_ret, exp_fpc;
  logic        exp_halt, exp_mis;

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_rd_valid = 1'b0; i_finished = 1'b0;
    i_pc_change = 1'b0; i_invalid_inst = 1'b0;
    #1;
    n_checks++; if (o_rd_ready !== 1'b0 || o_inst_valid !== 1'b0 || o_halted !== 1'b0)
      $display("FAIL rst_mask rdy/vld/halt got %b%b%b exp 000", o_rd_ready, o_inst_valid, o_halted);
    else n_pass++;
    tick(); tick();
    i_rst = 1'b0;
    sb.delete();
    exp_pc = 32'd0; exp_ret = 32'd0; exp_fpc = 32'd0; exp_halt = 1'b0; exp_mis = 1'b0;
    #1;
  endtask

  // Fetch one word after 'waits' cycles of i_rd_valid=0; leaves DUT in EXEC.
  task automatic fetch_word(input logic [31:0] data, input int waits);
    exp_t e;
    i_rd_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      #1;
      n_checks++; if (o_rd_ready !== 1'b1 || o_addr !== exp_pc || o_inst !== NOP || o_inst_valid !== 1'b0)
        $display("FAIL fetch_wait rdy=%b addr=%h inst=%h vld=%b exp 1 %h %h 0",
                 o_rd_ready, o_addr, o_inst, o_inst_valid, exp_pc, NOP);
      else n_pass++;
      tick();
    end
    i_data = data; i_rd_valid = 1'b1; #1;
    n_checks++; if (o_rd_ready !== 1'b1 || o_addr !== exp_pc)
      $display("FAIL fetch_req rdy=%b addr=%h exp 1 %h", o_rd_ready, o_addr, exp_pc);
    else n_pass++;
    sb.push_back('{inst: data, pc: exp_pc});
    tick();
    i_rd_valid = 1'b0; i_data = $urandom;
    #1;
    n_checks++;
    if (sb.size() == 0) $display("FAIL sb_empty no expected entry");
    else begin
      e = sb.pop_front();
      if (o_inst !== e.inst || o_pc !== e.pc || o_inst_valid !== 1'b1 || o_rd_ready !== 1'b0 || o_addr !== 32'd0)
        $display("FAIL exec_out inst=%h pc=%h vld=%b rdy=%b addr=%h exp %h %h 1 0 0",
                 o_inst, o_pc, o_inst_valid, o_rd_ready, o_addr, e.inst, e.pc);
      else n_pass++;
    end
  endtask

  // Hold i_finished low 'hold' cycles, then finish; updates model and checks.
  task automatic exec_finish(input int hold, input logic chg, input logic [31:0] npc, input logic inv);
    logic [31:0] inst0;
    inst0 = o_inst;
    for (int h = 0; h < hold; h++) begin
      i_finished = 1'b0; i_pc_change = chg; i_new_pc = npc; #1;
      n_checks++; if (o_inst_valid !== 1'b1 || o_inst !== inst0 || o_pc !== exp_pc || o_rd_ready !== 1'b0)
        $display("FAIL exec_hold vld=%b inst=%h pc=%h rdy=%b exp 1 %h %h 0",
                 o_inst_valid, o_inst, o_pc, o_rd_ready, inst0, exp_pc);
      else n_pass++;
      tick();
    end
    i_finished = 1'b1; i_pc_change = chg; i_new_pc = npc; i_invalid_inst = inv;
    tick();
    i_finished = 1'b0; i_pc_change = 1'b0; i_invalid_inst = 1'b0;
    if (inv) begin
      exp_halt = 1'b1; exp_fpc = exp_pc; exp_mis = 1'b0;
    end else if (chg && npc[1:0] != 2'b00) begin
      exp_halt = 1'b1; exp_fpc = exp_pc; exp_mis = 1'b1;
    end else begin
      exp_pc = chg ? npc : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
    end
    #1;
    n_checks++;
    if (o_halted !== exp_halt || o_rd_ready !== !exp_halt || o_pc !== exp_pc || o_retired !== exp_ret ||
        o_inst_valid !== 1'b0 || o_inst !== NOP || o_addr !== (exp_halt ? 32'd0 : exp_pc))
      $display("FAIL finish halt=%b rdy=%b pc=%h ret=%0d vld=%b inst=%h addr=%h exp halt=%b pc=%h ret=%0d",
               o_halted, o_rd_ready, o_pc, o_retired, o_inst_valid, o_inst, o_addr, exp_halt, exp_pc, exp_ret);
    else n_pass++;
    n_checks++;
    if (o_fault_pc !== exp_fpc || o_fault_misalign !== exp_mis)
      $display("FAIL fault_info fpc=%h mis=%b exp %h %b", o_fault_pc, o_fault_misalign, exp_fpc, exp_mis);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_rd_ready !== 1'b1 || o_addr !== 32'd0 || o_inst !== NOP || o_inst_valid !== 1'b0 ||
        o_halted !== 1'b0 || o_retired !== 32'd0 || o_pc !== 32'd0 || o_fault_pc !== 32'd0 || o_fault_misalign !== 1'b0)
      $display("FAIL reset_state rdy=%b addr=%h inst=%h vld=%b halt=%b ret=%0d pc=%h fpc=%h mis=%b",
               o_rd_ready, o_addr, o_inst, o_inst_valid, o_halted, o_retired, o_pc, o_fault_pc, o_fault_misalign);
    else n_pass++;
  endtask

  task automatic test_basic();
    fetch_word(32'h0050_0093, 0);
    exec_finish(0, 1'b0, 32'd0, 1'b0);   // expect o_addr=4, retired=1
  endtask

  task automatic test_wait_mem();
    fetch_word(32'hDEAD_BEEF, 3);
    exec_finish(0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_redirect_hold();
    fetch_word(32'h0000_006F, 0);
    exec_finish(4, 1'b1, 32'h40, 1'b0);  // next fetch at 0x40
  endtask

  task automatic test_back_to_back();
    logic [31:0] ret0;
    ret0 = o_retired;
    i_rd_valid = 1'b1; i_finished = 1'b1; i_pc_change = 1'b0;
    for (int c = 0; c < 10; c++) begin
      i_data = $urandom;
      tick();
      n_checks++;
      if (o_inst_valid !== ((c % 2) == 0))
        $display("FAIL b2b_phase cyc=%0d vld=%b exp %b", c, o_inst_valid, (c % 2) == 0);
      else n_pass++;
    end
    i_rd_valid = 1'b0; i_finished = 1'b0;
    exp_pc = exp_pc + 32'd20; exp_ret = exp_ret + 32'd5;
    #1;
    n_checks++;
    if (o_retired !== ret0 + 32'd5 || o_addr !== exp_pc || o_rd_ready !== 1'b1)
      $display("FAIL b2b_rate ret=%0d addr=%h exp %0d %h", o_retired, o_addr, ret0 + 32'd5, exp_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    fetch_word(32'h0000_0013, 0);
    exec_finish(0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch_word(32'h1234_5678, 1);
    exec_finish(0, 1'b0, 32'd0, 1'b0);   // PC wraps to 0, no fault
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_word(32'h0000_0001, 0); exec_finish(0, 1'b0, 32'd0, 1'b0);
    fetch_word(32'h0000_0002, 0); exec_finish(0, 1'b0, 32'd0, 1'b0);
    fetch_word(32'h0000_0003, 0); exec_finish(0, 1'b1, 32'h42, 1'b0);
    // HALT ignores everything except reset
    i_rd_valid = 1'b1; i_finished = 1'b1; i_pc_change = 1'b1; i_new_pc = 32'h100; i_invalid_inst = 1'b1;
    tick(); tick(); tick();
    i_rd_valid = 1'b0; i_finished = 1'b0; i_pc_change = 1'b0; i_invalid_inst = 1'b0;
    n_checks++;
    if (o_halted !== 1'b1 || o_rd_ready !== 1'b0 || o_fault_pc !== 32'h8 || o_fault_misalign !== 1'b1 ||
        o_retired !== 32'd2 || o_pc !== 32'h8 || o_inst !== NOP)
      $display("FAIL halt_sticky halt=%b rdy=%b fpc=%h mis=%b ret=%0d pc=%h inst=%h exp 1 0 8 1 2 8 %h",
               o_halted, o_rd_ready, o_fault_pc, o_fault_misalign, o_retired, o_pc, o_inst, NOP);
    else n_pass++;
  endtask

  task automatic test_invalid();
    do_reset();
    fetch_word(32'h0100_006F, 0); exec_finish(0, 1'b1, 32'h10, 1'b0);
    fetch_word(32'hFFFF_FFFF, 0);
    i_finished = 1'b1;                     // invalid wins over finished
    exec_finish(0, 1'b0, 32'd0, 1'b1);     // fault_pc=0x10, mis=0, retired=1
    do_reset();                            // reset out of HALT
    n_checks++;
    if (o_halted !== 1'b0 || o_rd_ready !== 1'b1 || o_addr !== 32'd0 || o_retired !== 32'd0 ||
        o_fault_pc !== 32'd0 || o_fault_misalign !== 1'b0)
      $display("FAIL halt_reset halt=%b rdy=%b addr=%h ret=%0d fpc=%h mis=%b exp 0 1 0 0 0 0",
               o_halted, o_rd_ready, o_addr, o_retired, o_fault_pc, o_fault_misalign);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    // reset during EXEC after some progress
    fetch_word(32'h0000_0aaa, 0); exec_finish(0, 1'b0, 32'd0, 1'b0);
    fetch_word(32'h0000_0bbb, 0);
    i_finished = 1'b1;
    do_reset();
    n_checks++;
    if (o_addr !== 32'd0 || o_retired !== 32'd0 || o_inst_valid !== 1'b0 || o_rd_ready !== 1'b1)
      $display("FAIL rst_exec addr=%h ret=%0d vld=%b rdy=%b exp 0 0 0 1", o_addr, o_retired, o_inst_valid, o_rd_ready);
    else n_pass++;
    // reset on a FETCH cycle with a response present: word dropped
    fetch_word(32'h0000_0ccc, 0); exec_finish(0, 1'b0, 32'd0, 1'b0);
    i_rst = 1'b1; i_data = 32'hBAD0_BAD0; i_rd_valid = 1'b1; #1;
    n_checks++; if (o_rd_ready !== 1'b0)
      $display("FAIL rst_fetch_rdy got %b exp 0", o_rd_ready);
    else n_pass++;
    tick();
    i_rd_valid = 1'b0; i_rst = 1'b0;
    sb.delete(); exp_pc = 32'd0; exp_ret = 32'd0;
    #1;
    n_checks++;
    if (o_inst_valid !== 1'b0 || o_rd_ready !== 1'b1 || o_addr !== 32'd0 || o_inst !== NOP || o_retired !== 32'd0)
      $display("FAIL rst_drop vld=%b rdy=%b addr=%h inst=%h ret=%0d exp 0 1 0 %h 0",
               o_inst_valid, o_rd_ready, o_addr, o_inst, o_retired, NOP);
    else n_pass++;
    fetch_word(32'h0000_0ddd, 0); exec_finish(0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wait_mem();
    test_redirect_hold();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_invalid();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
